pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enables and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles three cases: load-use hazards, branch-taken flushes, and variable-latency data-memory accesses via a ready handshake, with a timeout watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait with watchdog, branch flush, load-use stall.
// Define HAZARD_PERF_CNT_EN to add saturating perf_mem_stall / perf_lu_stall / perf_flush counters.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int WAIT_W      = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       ex_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       ifid_we,
   output logic       ifid_flush,
   output logic       idex_we,
   output logic       idex_bubble,
   output logic       exmem_we,
   output logic       memwb_bubble,
   output logic       mem_err,
   output logic       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [15:0] perf_mem_stall,
   output logic [15:0] perf_lu_stall,
   output logic [15:0] perf_flush
`endif
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} ctrlState_t;

   localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] ONE_CNT     = WAIT_W'(1);

   ctrlState_t        state, stateNext;
   logic [WAIT_W-1:0] waitCnt, waitCntNext;
   logic              memErr;
   logic              memStall, branchFlush, luStall, watchdogFire, luMatch;

   assign luMatch = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // Event decode in priority order; branch and load-use only matter in RUN.
   always_comb begin
      stateNext    = state;
      waitCntNext  = waitCnt;
      memStall     = 1'b0;
      branchFlush  = 1'b0;
      luStall      = 1'b0;
      watchdogFire = 1'b0;
      case (state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               memStall    = 1'b1;
               stateNext   = MEM_WAIT;
               waitCntNext = ONE_CNT;
            end else if (ex_branch_taken) begin
               branchFlush = 1'b1;
            end else if (luMatch) begin
               luStall = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               stateNext   = RUN;
               waitCntNext = '0;
            end else if (waitCnt == TIMEOUT_CNT) begin
               watchdogFire = 1'b1;
               stateNext    = RUN;
               waitCntNext  = '0;
            end else begin
               memStall = 1'b1;
               if (waitCnt != '1) waitCntNext = waitCnt + ONE_CNT;
            end
         end
      endcase
   end

   always_comb begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      ifid_flush   = 1'b0;
      idex_we      = 1'b1;
      idex_bubble  = 1'b0;
      exmem_we     = 1'b1;
      memwb_bubble = 1'b0;
      if (reset) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (memStall) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (branchFlush) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (luStall) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= RUN;
         waitCnt <= '0;
         memErr  <= 1'b0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
         memErr  <= memErr | watchdogFire;
      end
   end

   assign mem_err    = memErr;
   assign ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_mem_stall <= '0;
         perf_lu_stall  <= '0;
         perf_flush     <= '0;
      end else begin
         if (memStall && perf_mem_stall != 16'hFFFF) perf_mem_stall <= perf_mem_stall + 16'd1;
         if (luStall && perf_lu_stall != 16'hFFFF)   perf_lu_stall  <= perf_lu_stall + 16'd1;
         if (branchFlush && perf_flush != 16'hFFFF)  perf_flush     <= perf_flush + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 15;
   localparam int WAIT_W      = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
   logic       mem_req = 1'b0, mem_ready = 1'b0;
   logic       pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, mem_err, ctrl_state;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .WAIT_W(WAIT_W)) dut (
      .clock(clock), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
      .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_bubble(memwb_bubble),
      .mem_err(mem_err), .ctrl_state(ctrl_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [8:0] outs;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: are we waiting on memory, how many wait cycles so far, has the watchdog fired.
   bit mWait = 0;
   int mCycles = 0;
   bit mErr = 0;

   function automatic logic [8:0] packOuts(logic pcW, logic ifW, logic fl, logic idW, logic idB,
                                           logic exW, logic wbB, logic er, logic st);
      return {pcW, ifW, fl, idW, idB, exW, wbB, er, st};
   endfunction

   task automatic modelStep(input string nm);
      logic pcW, ifW, fl, idW, idB, exW, wbB;
      bit   hazard, errNow, waitNow;
      exp_t e;
      pcW = 1; ifW = 1; fl = 0; idW = 1; idB = 0; exW = 1; wbB = 0;
      errNow  = mErr;
      waitNow = mWait;
      hazard  = ex_memread && ex_rt != 0 &&
                (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
      if (!mWait) begin
         if (mem_req && !mem_ready) begin
            pcW = 0; ifW = 0; idW = 0; exW = 0; wbB = 1;
            mWait = 1; mCycles = 1;
         end else if (ex_branch_taken) begin
            fl = 1; idB = 1;
         end else if (hazard) begin
            pcW = 0; ifW = 0; idB = 1;
         end
      end else if (mem_ready) begin
         mWait = 0; mCycles = 0;
      end else if (mCycles >= MEM_TIMEOUT) begin
         mWait = 0; mCycles = 0; mErr = 1;
      end else begin
         pcW = 0; ifW = 0; idW = 0; exW = 0; wbB = 1;
         mCycles = mCycles + 1;
      end
      e.name = nm;
      e.outs = packOuts(pcW, ifW, fl, idW, idB, exW, wbB, errNow, waitNow);
      sbq.push_back(e);
   endtask

   task automatic pushReset(input string nm);
      exp_t e;
      e.name = nm;
      e.outs = packOuts(0, 0, 0, 0, 1, 0, 1, 0, 0);
      sbq.push_back(e);
      mWait = 0; mCycles = 0; mErr = 0;
   endtask

   task automatic drive(input string nm, input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                        input logic memRd, input logic [4:0] exRt, input logic br,
                        input logic req, input logic rdy);
      @(posedge clock);
      #1;
      id_rs = rs; id_rt = rt; id_uses_rt = usesRt;
      ex_memread = memRd; ex_rt = exRt; ex_branch_taken = br;
      mem_req = req; mem_ready = rdy;
      modelStep(nm);
   endtask

   task automatic idle(input string nm);
      drive(nm, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are combinational, so every cycle with a pending expectation is checked mid-cycle.
   initial begin
      exp_t       e;
      logic [8:0] got;
      forever begin
         @(negedge clock);
         if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            got = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, mem_err, ctrl_state};
            checks++;
            if (got !== e.outs) begin
               errors++;
               $display("FAIL %s: got %b expected %b (pc ifid flush idex bub exmem wbbub err state)",
                        e.name, got, e.outs);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      pushReset("reset_hold");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      drive("lu_stall", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      drive("lu_clear", 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
      drive("r0_nostall", 5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      drive("rt_unused", 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      drive("rt_used", 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      drive("zero_lat_mem", 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 3; i++) drive("mem_wait", 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      drive("mem_release", 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      idle("mem_after");

      drive("prio_freeze", 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
      drive("prio_release", 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
      drive("prio_flush", 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      idle("prio_after");

      for (int i = 0; i < 400; i++) begin
         logic [4:0] rs, rt, er;
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         er = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         drive("random", rs, rt, 1'($urandom), 1'($urandom_range(0, 2) != 0), er,
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 2) == 0));
      end
      idle("random_drain");

      for (int i = 0; i < MEM_TIMEOUT + 2; i++)
         drive("watchdog", 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, i < 1, 1'b0);
      for (int i = 0; i < 3; i++) idle("err_sticky");
      drive("err_lu", 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) drive("pre_reset_wait", 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      mem_req = 1'b0; mem_ready = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
      #1 reset = 1'b1;
      pushReset("async_reset");
      @(posedge clock);
      #1 reset = 1'b0;
      idle("post_reset");
      drive("post_reset_flush", 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      drive("post_reset_lu", 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      idle("post_reset_idle");

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clock);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
